// File: rtl/fix_pkg.sv
// fix_pkg: shared state type and ASCII constants for the FIX checksum generator
package fix_pkg;
  localparam int CHK_W = 8;
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ = 8'h3D;
  localparam logic [7:0] ZERO = 8'h30;
  typedef enum logic [2:0] {IDLE, ACCUM, DIG_H, DIG_T, DIG_O} state_t;
endpackage

// File: rtl/fix_bin2ascii3.sv
// fix_bin2ascii3: steps an 8-bit value out as three ASCII decimal digits
// load/load_val capture the value; step consumes the digit picked by sel
// (0=hundreds, 1=tens, 2=ones); digit is the ASCII digit for sel.
module fix_bin2ascii3
  import fix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CHK_W-1:0] load_val,
  input  logic             step,
  input  logic [1:0]       sel,
  output logic [7:0]       digit
);
  logic [CHK_W-1:0] rem, hund, tens;
  always_comb begin
    hund = rem >= 8'd200 ? 8'd2 : rem >= 8'd100 ? 8'd1 : 8'd0;
    tens = rem / 8'd10;
    digit = ZERO + (sel == 2'd0 ? hund : sel == 2'd1 ? tens : rem);
  end
  always_ff @(posedge clk)
    if (rst) rem <= '0;
    else if (load) rem <= load_val;
    else if (step) rem <= sel == 2'd0 ? rem - hund * 8'd100 : rem % 8'd10;
endmodule

// File: rtl/fix_checksum_gen.sv
// fix_checksum_gen: FIX tag-10 checksum over the creator's byte stream
// data_i/data_valid_i snoop emitted bytes; start_i/end_i bracket the summed
// region; chk_digit_o/chk_valid_o/chk_idx_o return three ASCII digits on
// E+1..E+3; chk_bin_o holds the binary checksum; busy_o flags activity.
module fix_checksum_gen
  import fix_pkg::*;
#(
  parameter int PRE_BYTES  = 1,
  parameter int POST_EXCL  = 2,
  parameter int HIST_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  input  logic             start_i,
  input  logic             end_i,
  output logic [7:0]       chk_digit_o,
  output logic             chk_valid_o,
  output logic [1:0]       chk_idx_o,
  output logic [CHK_W-1:0] chk_bin_o,
  output logic             busy_o
);
  state_t state, state_n;
  logic [7:0] hist [HIST_DEPTH];
  logic [CHK_W-1:0] sum, pre_sum, chk;
  logic [1:0] cnt;
  logic do_start, do_acc, do_end;
  logic [7:0] digit;
  always_comb begin
    do_end = state == ACCUM && data_valid_i && end_i;
    do_start = data_valid_i && start_i && (state == IDLE || (state == ACCUM && !end_i));
    do_acc = state == ACCUM && data_valid_i && !start_i && !end_i;
    pre_sum = data_i;
    for (int i = 0; i < PRE_BYTES; i++) pre_sum = pre_sum + hist[i];
    // strip the trailing "10" tag bytes, but never reach back before start
    chk = sum;
    for (int i = 0; i < POST_EXCL; i++) if (2'(i) < cnt) chk = chk - hist[i];
    state_n = state == IDLE  ? (data_valid_i && start_i ? ACCUM : IDLE) :
              state == ACCUM ? (do_end ? DIG_H : ACCUM) :
              state == DIG_H ? DIG_T :
              state == DIG_T ? DIG_O : IDLE;
    chk_valid_o = state == DIG_H || state == DIG_T || state == DIG_O;
    chk_idx_o = state == DIG_T ? 2'd1 : state == DIG_O ? 2'd2 : 2'd0;
    chk_digit_o = chk_valid_o ? digit : 8'd0;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      sum <= '0;
      cnt <= '0;
      chk_bin_o <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      if (data_valid_i) begin
        hist[0] <= data_i;
        for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
      end
      if (do_start) begin
        sum <= pre_sum;
        cnt <= 2'd1;
      end else if (do_acc) begin
        sum <= sum + data_i;
        cnt <= cnt == 2'd3 ? cnt : cnt + 2'd1;
      end
      if (do_end) chk_bin_o <= chk;
    end
  fix_bin2ascii3 u_conv (
    .clk      (clk),
    .rst      (rst),
    .load     (do_end),
    .load_val (chk),
    .step     (state == DIG_H || state == DIG_T),
    .sel      (chk_idx_o),
    .digit    (digit)
  );
endmodule
